match_event_monitor: RTL and testbench

//  Downstream consumer of the serial pattern detector's match flag. Turns each rising edge
//  of the flag into a counted event and keeps a saturating lifetime count. Raises a

---
 rtl/seq_mon_pkg.sv | 13 +
 rtl/rise_edge_det.sv | 23 ++
 rtl/match_event_monitor.sv | 145 ++++++++++++++
 tb/tb_match_event_monitor.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_mon_pkg.sv
// Shared types and constants for the match event monitor.
package seq_mon_pkg;

    localparam int STATE_W   = 2;
    localparam int WIN_CNT_W = 8;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        WINDOW = 2'd1,
        ALARM  = 2'd2
    } state_t;

endpackage

// File: rtl/rise_edge_det.sv
// Rising-edge detector for the detector's match flag, gated by the monitor enable.
module rise_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d,
    output logic pulse
);

    logic d_reg;

    // d_reg tracks the input even while disabled, so a flag already high at enable is not an event
    always_ff @(posedge clk) begin
        if (rst) begin
            d_reg <= 1'b0;
        end else begin
            d_reg <= d;
        end
    end

    assign pulse = en & d & ~d_reg;

endmodule

// File: rtl/match_event_monitor.sv
// Counts rising edges of the match flag and raises a held alarm on THRESH events in a window.
// Optional MATCH_STAMP_EN adds a free-running cycle counter that stamps the latest event.
module match_event_monitor
    import seq_mon_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int WIN_LEN = 32,
    parameter int THRESH  = 3,
    parameter int HOLD    = 8,
    parameter int STAMP_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               w,
    input  logic               en,
    input  logic               clr,
    output logic [CNT_W-1:0]   total_cnt,
    output logic [7:0]         win_cnt,
    output logic               alarm,
    output logic               busy,
    output logic [STAMP_W-1:0] last_stamp
);

    localparam int TMR_W = $clog2(WIN_LEN);
    localparam int HLD_W = $clog2(HOLD) + 1;

    localparam logic [TMR_W-1:0]     TMR_LOAD = TMR_W'(WIN_LEN - 1);
    localparam logic [TMR_W-1:0]     TMR_ONE  = TMR_W'(1);
    localparam logic [HLD_W-1:0]     HLD_LOAD = HLD_W'(HOLD - 1);
    localparam logic [HLD_W-1:0]     HLD_ONE  = HLD_W'(1);
    localparam logic [WIN_CNT_W-1:0] THRESH_C = WIN_CNT_W'(THRESH);
    localparam logic [WIN_CNT_W-1:0] WIN_ONE  = WIN_CNT_W'(1);
    localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);

    logic                 ev;
    state_t               state_reg;
    logic [TMR_W-1:0]     timer_reg;
    logic [HLD_W-1:0]     hold_reg;
    logic [WIN_CNT_W-1:0] win_cnt_reg;
    logic [WIN_CNT_W-1:0] win_cnt_next;
    logic [CNT_W-1:0]     total_reg;

    rise_edge_det u_edge (
        .clk   (clk),
        .rst   (rst | clr),
        .en    (en),
        .d     (w),
        .pulse (ev)
    );

    assign win_cnt_next = win_cnt_reg + WIN_ONE;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state_reg   <= IDLE;
            timer_reg   <= '0;
            hold_reg    <= '0;
            win_cnt_reg <= '0;
            total_reg   <= '0;
        end else begin
            if (ev && (total_reg != '1)) begin
                total_reg <= total_reg + CNT_ONE;
            end

            if (!en) begin
                state_reg   <= IDLE;
                timer_reg   <= '0;
                hold_reg    <= '0;
                win_cnt_reg <= '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (ev) begin
                            win_cnt_reg <= WIN_ONE;
                            if (THRESH == 1) begin
                                state_reg <= ALARM;
                                hold_reg  <= HLD_LOAD;
                            end else begin
                                state_reg <= WINDOW;
                                timer_reg <= TMR_LOAD;
                            end
                        end
                    end
                    WINDOW: begin
                        if (timer_reg != '0) begin
                            timer_reg <= timer_reg - TMR_ONE;
                        end
                        // An event on the final window cycle still counts toward the threshold
                        if (ev && (win_cnt_next == THRESH_C)) begin
                            state_reg   <= ALARM;
                            win_cnt_reg <= win_cnt_next;
                            hold_reg    <= HLD_LOAD;
                        end else if (timer_reg == '0) begin
                            state_reg   <= IDLE;
                            win_cnt_reg <= '0;
                        end else if (ev) begin
                            win_cnt_reg <= win_cnt_next;
                        end
                    end
                    ALARM: begin
                        if (hold_reg == '0) begin
                            state_reg   <= IDLE;
                            win_cnt_reg <= '0;
                        end else begin
                            hold_reg <= hold_reg - HLD_ONE;
                        end
                    end
                    default: begin
                        state_reg   <= IDLE;
                        win_cnt_reg <= '0;
                    end
                endcase
            end
        end
    end

    assign total_cnt = total_reg;
    assign win_cnt   = win_cnt_reg;
    assign alarm     = (state_reg == ALARM);
    assign busy      = (state_reg == WINDOW);

`ifdef MATCH_STAMP_EN
    localparam logic [STAMP_W-1:0] STAMP_ONE = STAMP_W'(1);

    logic [STAMP_W-1:0] stamp_ctr_reg;
    logic [STAMP_W-1:0] last_stamp_reg;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            stamp_ctr_reg  <= '0;
            last_stamp_reg <= '0;
        end else begin
            stamp_ctr_reg <= stamp_ctr_reg + STAMP_ONE;
            if (ev) begin
                last_stamp_reg <= stamp_ctr_reg;
            end
        end
    end

    assign last_stamp = last_stamp_reg;
`else
    assign last_stamp = '0;
`endif

endmodule

// File: tb/tb_match_event_monitor.sv
// Directed, table-driven bench for match_event_monitor (default parameters plus a CNT_W=4 copy).
module tb_match_event_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        w   = 1'b0;
    logic        en  = 1'b1;
    logic        clr = 1'b0;
    logic [15:0] total_cnt;
    logic [7:0]  win_cnt;
    logic        alarm;
    logic        busy;
    logic [15:0] last_stamp;
    logic [3:0]  sat_total;
    logic [7:0]  sat_win;
    logic        sat_alarm;
    logic        sat_busy;
    logic [15:0] sat_stamp;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    match_event_monitor u_dut (
        .clk        (clk),
        .rst        (rst),
        .w          (w),
        .en         (en),
        .clr        (clr),
        .total_cnt  (total_cnt),
        .win_cnt    (win_cnt),
        .alarm      (alarm),
        .busy       (busy),
        .last_stamp (last_stamp)
    );

    match_event_monitor #(.CNT_W(4)) u_sat (
        .clk        (clk),
        .rst        (rst),
        .w          (w),
        .en         (en),
        .clr        (clr),
        .total_cnt  (sat_total),
        .win_cnt    (sat_win),
        .alarm      (sat_alarm),
        .busy       (sat_busy),
        .last_stamp (sat_stamp)
    );

    typedef struct {
        bit w;
        bit en;
        bit clr;
        int reps;
        int total;
        int win;
        bit alarm;
        bit busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit vw, input bit ven, input bit vclr, input int reps,
                       input int tot, input int wc, input bit al, input bit bz);
        vec_t v;
        v.w = vw; v.en = ven; v.clr = vclr; v.reps = reps;
        v.total = tot; v.win = wc; v.alarm = al; v.busy = bz;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held with w high: everything reads zero
        rst = 1'b1; w = 1'b1; en = 1'b1; clr = 1'b0;
        step();
        step();
        chk("rst_total", int'(total_cnt), 0);
        chk("rst_win", int'(win_cnt), 0);
        chk("rst_alarm", int'(alarm), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_stamp", int'(last_stamp), 0);
        chk("rst_sat_total", int'(sat_total), 0);
        $display("reset: total=%0d win=%0d alarm=%0d busy=%0d", total_cnt, win_cnt, alarm, busy);
        rst = 1'b0;
        step();
        chk("post_rst_total", int'(total_cnt), 1);
        chk("post_rst_busy", int'(busy), 1);
        step();
        step();
        chk("held_w_total", int'(total_cnt), 1);

        // Three pulses 5 cycles apart: alarm for cycles 11..18
        add(0,1,1,1, 0,0,0,0);
        add(1,1,0,1, 1,1,0,1);
        add(0,1,0,4, 1,1,0,1);
        add(1,1,0,1, 2,2,0,1);
        add(0,1,0,4, 2,2,0,1);
        add(1,1,0,1, 3,3,1,0);
        add(0,1,0,7, 3,3,1,0);
        add(0,1,0,1, 3,0,0,0);
        // Two pulses then quiet: window open cycles 1..32
        add(0,1,1,1, 0,0,0,0);
        add(1,1,0,1, 1,1,0,1);
        add(0,1,0,4, 1,1,0,1);
        add(1,1,0,1, 2,2,0,1);
        add(0,1,0,26, 2,2,0,1);
        add(0,1,0,1, 2,0,0,0);
        // Long w high, then pulse at t=31
        add(0,1,1,1, 0,0,0,0);
        add(1,1,0,4, 1,1,0,1);
        add(0,1,0,27, 1,1,0,1);
        add(1,1,0,1, 2,2,0,1);
        add(0,1,0,1, 2,0,0,0);
        // Third event on the timer==0 cycle still alarms; event in ALARM counts only in total
        add(0,1,1,1, 0,0,0,0);
        add(1,1,0,1, 1,1,0,1);
        add(0,1,0,4, 1,1,0,1);
        add(1,1,0,1, 2,2,0,1);
        add(0,1,0,26, 2,2,0,1);
        add(1,1,0,1, 3,3,1,0);
        add(0,1,0,2, 3,3,1,0);
        add(1,1,0,1, 4,3,1,0);
        add(0,1,0,5, 4,0,0,0);
        // Reach alarm again, then clr during ALARM
        add(1,1,0,1, 5,1,0,1);
        add(0,1,0,4, 5,1,0,1);
        add(1,1,0,1, 6,2,0,1);
        add(0,1,0,4, 6,2,0,1);
        add(1,1,0,1, 7,3,1,0);
        add(0,1,0,2, 7,3,1,0);
        add(0,1,1,1, 0,0,0,0);
        add(0,1,0,1, 0,0,0,0);
        // en low mid-window, w high while disabled, then alarm aborted by en low
        add(1,1,0,1, 1,1,0,1);
        add(0,0,0,1, 1,0,0,0);
        add(1,0,0,1, 1,0,0,0);
        add(1,1,0,1, 1,0,0,0);
        add(0,1,0,1, 1,0,0,0);
        add(1,1,0,1, 2,1,0,1);
        add(0,1,0,1, 2,1,0,1);
        add(1,1,0,1, 3,2,0,1);
        add(0,1,0,1, 3,2,0,1);
        add(1,1,0,1, 4,3,1,0);
        add(0,0,0,1, 4,0,0,0);

        foreach (vecs[i]) begin
            w = vecs[i].w; en = vecs[i].en; clr = vecs[i].clr;
            for (int r = 0; r < vecs[i].reps; r++) step();
            chk($sformatf("v%0d_total", i), int'(total_cnt), vecs[i].total);
            chk($sformatf("v%0d_win", i), int'(win_cnt), vecs[i].win);
            chk($sformatf("v%0d_alarm", i), int'(alarm), int'(vecs[i].alarm));
            chk($sformatf("v%0d_busy", i), int'(busy), int'(vecs[i].busy));
`ifndef MATCH_STAMP_EN
            chk($sformatf("v%0d_stamp", i), int'(last_stamp), 0);
`endif
            $display("vec %0d: w=%0d en=%0d clr=%0d x%0d -> total=%0d win=%0d alarm=%0d busy=%0d",
                     i, vecs[i].w, vecs[i].en, vecs[i].clr, vecs[i].reps,
                     total_cnt, win_cnt, alarm, busy);
        end

        // Saturation of a 4-bit lifetime counter
        w = 1'b0; en = 1'b1; clr = 1'b1;
        step();
        clr = 1'b0;
        chk("sat_clr", int'(sat_total), 0);
        for (int p = 0; p < 20; p++) begin
            w = 1'b1; step();
            w = 1'b0; step();
            if (p == 13) chk("sat_14", int'(sat_total), 14);
        end
        chk("sat_stick", int'(sat_total), 15);
        chk("sat_main_total", int'(total_cnt), 20);
        $display("saturation: sat_total=%0d main_total=%0d", sat_total, total_cnt);

        // Event stamps relative to the cycle after clr
        w = 1'b0; clr = 1'b1;
        step();
        clr = 1'b0;
        for (int t = 0; t < 3; t++) step();
        w = 1'b1; step();
`ifdef MATCH_STAMP_EN
        chk("stamp_3", int'(last_stamp), 3);
`else
        chk("stamp_3", int'(last_stamp), 0);
`endif
        w = 1'b0;
        for (int t = 4; t < 40; t++) step();
        w = 1'b1; step();
        w = 1'b0;
`ifdef MATCH_STAMP_EN
        chk("stamp_40", int'(last_stamp), 40);
`else
        chk("stamp_40", int'(last_stamp), 0);
`endif
        $display("stamp: last_stamp=%0d total=%0d", last_stamp, total_cnt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
